// File: rtl/fp_ll_wb_arbiter.sv
// FP long-latency write-port arbiter: merges FP load responses (via a
// branch-aware buffer) with the ll_fresp stream into one registered
// FP regfile write port plus fflags report.
module fp_ll_wb_arbiter #(
  parameter int MEM_Q_DEPTH  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_mem_valid,
  input  logic [6:0]  io_mem_bits_uop_pdst,
  input  logic [6:0]  io_mem_bits_uop_rob_idx,
  input  logic [19:0] io_mem_bits_uop_br_mask,
  input  logic [64:0] io_mem_bits_data,
  input  logic        io_ll_valid,
  output logic        io_ll_ready,
  input  logic [6:0]  io_ll_bits_uop_pdst,
  input  logic [6:0]  io_ll_bits_uop_rob_idx,
  input  logic [19:0] io_ll_bits_uop_br_mask,
  input  logic [64:0] io_ll_bits_data,
  input  logic        io_ll_bits_fflags_valid,
  input  logic [4:0]  io_ll_bits_fflags_bits_flags,
  input  logic [19:0] io_brupdate_b1_resolve_mask,
  input  logic [19:0] io_brupdate_b1_mispredict_mask,
  input  logic        io_flush,
  output logic        io_wb_valid,
  output logic [6:0]  io_wb_pdst,
  output logic [64:0] io_wb_data,
  output logic [6:0]  io_wb_rob_idx,
  output logic        io_fflags_valid,
  output logic [6:0]  io_fflags_rob_idx,
  output logic [4:0]  io_fflags_flags,
  output logic        io_mem_q_full,
  output logic        io_overflow_err
);
  localparam int PW = $clog2(MEM_Q_DEPTH);
  localparam int CW = $clog2(MEM_Q_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic        vld;
    logic [6:0]  pdst;
    logic [6:0]  rob_idx;
    logic [19:0] br_mask;
    logic [64:0] data;
  } mem_ent_t;

  typedef struct packed {
    logic        vld;
    logic [6:0]  pdst;
    logic [6:0]  rob_idx;
    logic [19:0] br_mask;
    logic [64:0] data;
    logic        ff_vld;
    logic [4:0]  flags;
  } out_reg_t;

  mem_ent_t        q [MEM_Q_DEPTH];
  logic [PW-1:0]   head_ptr, tail_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt;
  out_reg_t        r;

  logic     q_empty, q_full, starved, ll_win, deq, mem_ok, enq, ovf;
  mem_ent_t head;
  logic [19:0] res, misp;

  assign res  = io_brupdate_b1_resolve_mask;
  assign misp = io_brupdate_b1_mispredict_mask;

  // Arbitration and buffer control; ready never looks at io_ll_bits.
  always_comb begin
    q_empty     = (count == '0);
    q_full      = (count == CW'(MEM_Q_DEPTH));
    head        = q[head_ptr];
    starved     = (starve_cnt == SW'(STARVE_LIMIT));
    ll_win      = io_ll_valid && (q_empty || starved);
    io_ll_ready = !io_flush && (q_empty || (io_ll_valid && starved));
    deq         = !io_flush && !ll_win && !q_empty;
    mem_ok      = io_mem_valid && !io_flush && ((io_mem_bits_uop_br_mask & misp) == '0);
    // A full buffer can still accept when the head leaves this same cycle.
    enq         = mem_ok && (!q_full || deq);
    ovf         = mem_ok && q_full && !deq;
  end

  // Memory-response buffer: branch update on every entry, then enqueue/dequeue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_Q_DEPTH; i++) q[i] <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (io_flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      for (int i = 0; i < MEM_Q_DEPTH; i++) begin
        q[i].vld     <= q[i].vld && ((q[i].br_mask & misp) == '0);
        q[i].br_mask <= q[i].br_mask & ~res;
      end
      // Later assignment wins: a new entry may reuse the slot the head just vacated.
      if (enq) begin
        q[tail_ptr] <= '{vld: 1'b1, pdst: io_mem_bits_uop_pdst,
                         rob_idx: io_mem_bits_uop_rob_idx,
                         br_mask: io_mem_bits_uop_br_mask & ~res,
                         data: io_mem_bits_data};
        tail_ptr <= tail_ptr + PW'(1);
      end
      if (deq) head_ptr <= head_ptr + PW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // Sticky drop indicator, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   io_overflow_err <= 1'b0;
    else if (ovf) io_overflow_err <= 1'b1;
  end

  // Count consecutive lost arbitrations of a waiting ll uop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                  starve_cnt <= '0;
    else if (!io_ll_valid || (ll_win && !io_flush)) starve_cnt <= '0;
    else if (!io_ll_ready && !starved)           starve_cnt <= starve_cnt + SW'(1);
  end

  // Output register reloads every cycle from the arbitration winner.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r <= '0;
    end else if (io_flush) begin
      r.vld <= 1'b0;
    end else if (ll_win) begin
      r <= '{vld: (io_ll_bits_uop_br_mask & misp) == '0,
             pdst: io_ll_bits_uop_pdst, rob_idx: io_ll_bits_uop_rob_idx,
             br_mask: io_ll_bits_uop_br_mask & ~res, data: io_ll_bits_data,
             ff_vld: io_ll_bits_fflags_valid, flags: io_ll_bits_fflags_bits_flags};
    end else if (!q_empty) begin
      // Killed entries still drain through here, just marked invalid.
      r <= '{vld: head.vld && ((head.br_mask & misp) == '0),
             pdst: head.pdst, rob_idx: head.rob_idx,
             br_mask: head.br_mask & ~res, data: head.data,
             ff_vld: 1'b0, flags: 5'd0};
    end else begin
      r.vld <= 1'b0;
    end
  end

  assign io_wb_valid       = r.vld && ((r.br_mask & misp) == '0) && !io_flush;
  assign io_wb_pdst        = r.pdst;
  assign io_wb_data        = r.data;
  assign io_wb_rob_idx     = r.rob_idx;
  assign io_fflags_valid   = io_wb_valid && r.ff_vld;
  assign io_fflags_rob_idx = r.rob_idx;
  assign io_fflags_flags   = r.flags;
  assign io_mem_q_full     = q_full;

endmodule

// File: tb/tb_fp_ll_wb_arbiter.sv
// Self-checking bench for fp_ll_wb_arbiter: directed table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_fp_ll_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clock, reset;
  logic        io_mem_valid;
  logic [6:0]  io_mem_bits_uop_pdst, io_mem_bits_uop_rob_idx;
  logic [19:0] io_mem_bits_uop_br_mask;
  logic [64:0] io_mem_bits_data;
  logic        io_ll_valid, io_ll_ready;
  logic [6:0]  io_ll_bits_uop_pdst, io_ll_bits_uop_rob_idx;
  logic [19:0] io_ll_bits_uop_br_mask;
  logic [64:0] io_ll_bits_data;
  logic        io_ll_bits_fflags_valid;
  logic [4:0]  io_ll_bits_fflags_bits_flags;
  logic [19:0] io_brupdate_b1_resolve_mask, io_brupdate_b1_mispredict_mask;
  logic        io_flush;
  logic        io_wb_valid;
  logic [6:0]  io_wb_pdst, io_wb_rob_idx, io_fflags_rob_idx;
  logic [64:0] io_wb_data;
  logic        io_fflags_valid;
  logic [4:0]  io_fflags_flags;
  logic        io_mem_q_full, io_overflow_err;

  fp_ll_wb_arbiter #(.MEM_Q_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .io_mem_valid(io_mem_valid), .io_mem_bits_uop_pdst(io_mem_bits_uop_pdst),
    .io_mem_bits_uop_rob_idx(io_mem_bits_uop_rob_idx),
    .io_mem_bits_uop_br_mask(io_mem_bits_uop_br_mask), .io_mem_bits_data(io_mem_bits_data),
    .io_ll_valid(io_ll_valid), .io_ll_ready(io_ll_ready),
    .io_ll_bits_uop_pdst(io_ll_bits_uop_pdst), .io_ll_bits_uop_rob_idx(io_ll_bits_uop_rob_idx),
    .io_ll_bits_uop_br_mask(io_ll_bits_uop_br_mask), .io_ll_bits_data(io_ll_bits_data),
    .io_ll_bits_fflags_valid(io_ll_bits_fflags_valid),
    .io_ll_bits_fflags_bits_flags(io_ll_bits_fflags_bits_flags),
    .io_brupdate_b1_resolve_mask(io_brupdate_b1_resolve_mask),
    .io_brupdate_b1_mispredict_mask(io_brupdate_b1_mispredict_mask),
    .io_flush(io_flush),
    .io_wb_valid(io_wb_valid), .io_wb_pdst(io_wb_pdst), .io_wb_data(io_wb_data),
    .io_wb_rob_idx(io_wb_rob_idx), .io_fflags_valid(io_fflags_valid),
    .io_fflags_rob_idx(io_fflags_rob_idx), .io_fflags_flags(io_fflags_flags),
    .io_mem_q_full(io_mem_q_full), .io_overflow_err(io_overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit        v;
    bit [6:0]  pdst, rob;
    bit [19:0] mask;
    bit [64:0] data;
  } ment_t;

  ment_t     mq[$];
  bit        m_v, m_ff, m_ovf;
  bit [6:0]  m_pdst, m_rob;
  bit [19:0] m_mask;
  bit [64:0] m_data;
  bit [4:0]  m_flags;
  int        m_starve;

  task automatic model_reset();
    mq.delete();
    m_v = 0; m_ff = 0; m_ovf = 0; m_pdst = 0; m_rob = 0; m_mask = 0;
    m_data = 0; m_flags = 0; m_starve = 0;
  endtask

  function automatic bit exp_ready();
    return !io_flush && (mq.size() == 0 || (io_ll_valid && m_starve == LIMIT));
  endfunction

  task automatic compare_all();
    bit ew, ef;
    ew = m_v && ((m_mask & io_brupdate_b1_mispredict_mask) == 0) && !io_flush;
    ef = ew && m_ff;
    chk("ll_ready", 65'(io_ll_ready), 65'(exp_ready()));
    chk("wb_valid", 65'(io_wb_valid), 65'(ew));
    chk("fflags_valid", 65'(io_fflags_valid), 65'(ef));
    chk("mem_q_full", 65'(io_mem_q_full), 65'(mq.size() == DEPTH));
    chk("overflow_err", 65'(io_overflow_err), 65'(m_ovf));
    if (ew) begin
      chk("wb_pdst", 65'(io_wb_pdst), 65'(m_pdst));
      chk("wb_data", io_wb_data, m_data);
      chk("wb_rob_idx", 65'(io_wb_rob_idx), 65'(m_rob));
    end
    if (ef) begin
      chk("fflags_flags", 65'(io_fflags_flags), 65'(m_flags));
      chk("fflags_rob_idx", 65'(io_fflags_rob_idx), 65'(m_rob));
    end
  endtask

  task automatic model_step();
    bit    empty, win, rdy;
    ment_t h, n;
    bit [19:0] misp, res;
    misp  = io_brupdate_b1_mispredict_mask;
    res   = io_brupdate_b1_resolve_mask;
    empty = (mq.size() == 0);
    rdy   = exp_ready();
    win   = io_ll_valid && (empty || m_starve == LIMIT);
    if (io_flush) begin
      mq.delete();
      m_v = 0;
    end else begin
      if (win) begin
        m_v = (io_ll_bits_uop_br_mask & misp) == 0;
        m_pdst = io_ll_bits_uop_pdst; m_rob = io_ll_bits_uop_rob_idx;
        m_mask = io_ll_bits_uop_br_mask & ~res; m_data = io_ll_bits_data;
        m_ff = io_ll_bits_fflags_valid; m_flags = io_ll_bits_fflags_bits_flags;
      end else if (!empty) begin
        h = mq.pop_front();
        m_v = h.v && ((h.mask & misp) == 0);
        m_pdst = h.pdst; m_rob = h.rob; m_mask = h.mask & ~res; m_data = h.data;
        m_ff = 0; m_flags = 0;
      end else begin
        m_v = 0;
      end
      foreach (mq[i]) begin
        if ((mq[i].mask & misp) != 0) mq[i].v = 0;
        mq[i].mask = mq[i].mask & ~res;
      end
      if (io_mem_valid && ((io_mem_bits_uop_br_mask & misp) == 0)) begin
        if (mq.size() == DEPTH) m_ovf = 1;
        else begin
          n.v = 1; n.pdst = io_mem_bits_uop_pdst; n.rob = io_mem_bits_uop_rob_idx;
          n.mask = io_mem_bits_uop_br_mask & ~res; n.data = io_mem_bits_data;
          mq.push_back(n);
        end
      end
    end
    if (!io_ll_valid || (win && !io_flush)) m_starve = 0;
    else if (!rdy && m_starve < LIMIT) m_starve++;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [64:0] rnd65();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[64:0];
  endfunction

  function automatic logic [19:0] rmask();
    return ($urandom_range(0, 2) == 0) ? (20'h1 << $urandom_range(0, 3)) : 20'h0;
  endfunction

  task automatic set_idle();
    io_mem_valid = 0; io_mem_bits_uop_pdst = 0; io_mem_bits_uop_rob_idx = 0;
    io_mem_bits_uop_br_mask = 0; io_mem_bits_data = 0;
    io_ll_valid = 0; io_ll_bits_uop_pdst = 0; io_ll_bits_uop_rob_idx = 0;
    io_ll_bits_uop_br_mask = 0; io_ll_bits_data = 0;
    io_ll_bits_fflags_valid = 0; io_ll_bits_fflags_bits_flags = 0;
    io_brupdate_b1_resolve_mask = 0; io_brupdate_b1_mispredict_mask = 0;
    io_flush = 0;
  endtask

  task automatic set_mem(input logic [6:0] pdst, input logic [6:0] rob,
                         input logic [19:0] mask, input logic [64:0] data);
    io_mem_valid = 1; io_mem_bits_uop_pdst = pdst; io_mem_bits_uop_rob_idx = rob;
    io_mem_bits_uop_br_mask = mask; io_mem_bits_data = data;
  endtask

  task automatic set_ll(input logic [6:0] pdst, input logic [6:0] rob, input logic [19:0] mask,
                        input logic ffv, input logic [4:0] flags);
    io_ll_valid = 1; io_ll_bits_uop_pdst = pdst; io_ll_bits_uop_rob_idx = rob;
    io_ll_bits_uop_br_mask = mask; io_ll_bits_data = rnd65();
    io_ll_bits_fflags_valid = ffv; io_ll_bits_fflags_bits_flags = flags;
  endtask

  task automatic settle();
    #1;
    compare_all();
  endtask

  task automatic adv();
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wb_valid"}, 65'(io_wb_valid), 65'(0));
    chk({tag, "_fflags_valid"}, 65'(io_fflags_valid), 65'(0));
    chk({tag, "_mem_q_full"}, 65'(io_mem_q_full), 65'(0));
    chk({tag, "_overflow"}, 65'(io_overflow_err), 65'(0));
    chk({tag, "_ll_ready"}, 65'(io_ll_ready), 65'(1));
    chk({tag, "_wb_pdst"}, 65'(io_wb_pdst), 65'(0));
    chk({tag, "_wb_data"}, io_wb_data, 65'(0));
    chk({tag, "_wb_rob"}, 65'(io_wb_rob_idx), 65'(0));
  endtask

  // Called just after a falling edge; asserts reset before the next rising edge.
  task automatic do_reset(input string tag);
    set_idle();
    #1 reset = 0;
    #1 check_reset_vals(tag);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1;
  endtask

  // Fill the buffer with [A, B] by letting the starved ll uop win once.
  task automatic build_two(input logic [19:0] ma, input logic [19:0] mb);
    for (int c = 0; c < 6; c++) begin
      set_idle();
      set_ll(7'(30 + c), 7'(40 + c), 20'h0, 0, 5'd0);
      if (c < 4)       set_mem(7'(50 + c), 7'(60 + c), 20'h0, rnd65());
      else if (c == 4) set_mem(7'd20, 7'd70, ma, 65'h0AAAA);
      else             set_mem(7'd21, 7'd71, mb, 65'h0BBBB);
      cyc();
    end
    set_idle();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit        mem_v;
    bit [6:0]  mem_pdst, mem_rob;
    bit [64:0] mem_data;
    bit        ll_v;
    bit [6:0]  ll_pdst, ll_rob;
    bit        ll_ffv;
    bit [4:0]  ll_flags;
    bit        e_ready, e_wb, e_ff;
    bit [6:0]  e_pdst, e_rob;
    bit [64:0] e_data;
    bit [4:0]  e_flags;
  } vec_t;

  vec_t tbl[10];

  initial begin
    vec_t v;
    reset = 1;
    set_idle();
    model_reset();
    #2 reset = 0;
    #1 check_reset_vals("rst0");
    @(negedge clock);
    @(negedge clock);
    reset = 1;

    //        mem_v pdst rob data                     ll_v pdst rob ffv flags  rdy wb ff pdst rob data                     flags
    tbl[0] = '{1, 5, 3, 65'h1_0000_0000_3F80_0000,   0, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0,                           0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 0,                           0, 0, 0, 0, 0,          1, 1, 0, 5, 3, 65'h1_0000_0000_3F80_0000, 0};
    tbl[3] = '{0, 0, 0, 0,                           1, 9, 12, 1, 5'h10,     1, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{0, 0, 0, 0,                           0, 0, 0, 0, 0,          1, 1, 1, 9, 12, 65'h0123, 5'h10};
    tbl[5] = '{0, 0, 0, 0,                           0, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0, 0};
    tbl[6] = '{1, 7, 4, 65'h1_DEAD_BEEF,             1, 10, 13, 0, 5'h3,     1, 0, 0, 0, 0, 0, 0};
    tbl[7] = '{0, 0, 0, 0,                           0, 0, 0, 0, 0,          0, 1, 0, 10, 13, 65'h0123, 0};
    tbl[8] = '{0, 0, 0, 0,                           0, 0, 0, 0, 0,          1, 1, 0, 7, 4, 65'h1_DEAD_BEEF, 0};
    tbl[9] = '{0, 0, 0, 0,                           0, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0, 0};

    foreach (tbl[i]) begin
      v = tbl[i];
      set_idle();
      if (v.mem_v) set_mem(v.mem_pdst, v.mem_rob, 20'h0, v.mem_data);
      if (v.ll_v) begin
        set_ll(v.ll_pdst, v.ll_rob, 20'h0, v.ll_ffv, v.ll_flags);
        io_ll_bits_data = 65'h0123;
      end
      settle();
      chk($sformatf("tbl%0d_ready", i), 65'(io_ll_ready), 65'(v.e_ready));
      chk($sformatf("tbl%0d_wb", i), 65'(io_wb_valid), 65'(v.e_wb));
      chk($sformatf("tbl%0d_ff", i), 65'(io_fflags_valid), 65'(v.e_ff));
      if (v.e_wb) begin
        chk($sformatf("tbl%0d_pdst", i), 65'(io_wb_pdst), 65'(v.e_pdst));
        chk($sformatf("tbl%0d_rob", i), 65'(io_wb_rob_idx), 65'(v.e_rob));
        chk($sformatf("tbl%0d_data", i), io_wb_data, v.e_data);
      end
      if (v.e_ff) begin
        chk($sformatf("tbl%0d_flags", i), 65'(io_fflags_flags), 65'(v.e_flags));
        chk($sformatf("tbl%0d_ffrob", i), 65'(io_fflags_rob_idx), 65'(v.e_rob));
      end
      adv();
    end

    // Starvation: ll granted every 5th cycle; a grant while full drops mem.
    do_reset("rst1");
    for (int c = 0; c < 11; c++) begin
      set_idle();
      set_mem(7'(c), 7'(c), 20'h0, rnd65());
      set_ll(7'(64 + c), 7'(c), 20'h0, 0, 5'd0);
      settle();
      chk($sformatf("starve_ready_c%0d", c), 65'(io_ll_ready), 65'((c % 5) == 0));
      if (c == 10) chk("starve_ovf_before", 65'(io_overflow_err), 65'(0));
      adv();
    end
    for (int c = 0; c < 3; c++) begin
      set_idle();
      settle();
      chk("ovf_sticky", 65'(io_overflow_err), 65'(1));
      adv();
    end

    // Branch kill of buffered head.
    do_reset("rst2");
    build_two(20'h1, 20'h2);
    settle();
    chk("two_full", 65'(io_mem_q_full), 65'(1));
    io_brupdate_b1_mispredict_mask = 20'h1;
    settle();
    adv();
    set_idle();
    settle();
    chk("kill_a_wb", 65'(io_wb_valid), 65'(0));
    adv();
    settle();
    chk("kill_b_wb", 65'(io_wb_valid), 65'(1));
    chk("kill_b_pdst", 65'(io_wb_pdst), 65'(21));
    adv();

    // Resolve clears a bit so a later mispredict on it is harmless.
    do_reset("rst3");
    build_two(20'h1, 20'h2);
    io_brupdate_b1_resolve_mask = 20'h2;
    cyc();
    set_idle();
    io_brupdate_b1_mispredict_mask = 20'h2;
    settle();
    chk("res_a_wb", 65'(io_wb_valid), 65'(1));
    chk("res_a_pdst", 65'(io_wb_pdst), 65'(20));
    adv();
    set_idle();
    settle();
    chk("res_b_wb", 65'(io_wb_valid), 65'(1));
    chk("res_b_pdst", 65'(io_wb_pdst), 65'(21));
    adv();

    // Output-stage kill.
    do_reset("rst4");
    set_ll(7'd11, 7'd22, 20'h4, 1, 5'h1);
    settle();
    chk("ostage_ready", 65'(io_ll_ready), 65'(1));
    adv();
    set_idle();
    io_brupdate_b1_mispredict_mask = 20'h4;
    settle();
    chk("ostage_kill", 65'(io_wb_valid), 65'(0));
    adv();

    // Flush with a full buffer and pending ll.
    do_reset("rst5");
    build_two(20'h0, 20'h0);
    io_flush = 1;
    set_ll(7'd3, 7'd3, 20'h0, 0, 5'd0);
    set_mem(7'd4, 7'd4, 20'h0, rnd65());
    settle();
    chk("flush_ready", 65'(io_ll_ready), 65'(0));
    chk("flush_wb", 65'(io_wb_valid), 65'(0));
    adv();
    for (int c = 0; c < 3; c++) begin
      set_idle();
      settle();
      chk($sformatf("flush_wb_c%0d", c), 65'(io_wb_valid), 65'(0));
      if (c == 0) chk("flush_full", 65'(io_mem_q_full), 65'(0));
      adv();
    end

    // Randomized traffic with a mid-stream async reset.
    do_reset("rst6");
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset("rst_mid");
      set_idle();
      if ($urandom_range(0, 1) == 1)
        set_mem(7'($urandom), 7'($urandom), rmask(), rnd65());
      if ($urandom_range(0, 9) < 6)
        set_ll(7'($urandom), 7'($urandom), rmask(), 1'($urandom), 5'($urandom));
      if ($urandom_range(0, 5) == 0) io_brupdate_b1_resolve_mask = rmask();
      if ($urandom_range(0, 11) == 0)
        io_brupdate_b1_mispredict_mask = 20'h1 << $urandom_range(0, 3);
      io_flush = ($urandom_range(0, 49) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
